// File: rtl/task7_eval_sequencer.sv
// Sequencer for y = 0.5*x + x^2*cos((x-128)/128) on one float32 sample at a time,
// time-sharing one FP multiplier, one FP add/sub unit and one cosine unit.
module task7_eval_sequencer #(
    parameter int MUL_LAT     = 2,
    parameter int ADD_LAT     = 3,
    parameter int COS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_res,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_sub,
    input  logic [31:0] add_res,
    output logic [31:0] cos_angle,
    output logic        cos_start,
    input  logic        cos_done,
    input  logic [31:0] cos_res,
    output logic        cos_reset
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SUB   = 4'd1;
    localparam logic [3:0] S_SCALE = 4'd2;
    localparam logic [3:0] S_COS   = 4'd3;
    localparam logic [3:0] S_HALF  = 4'd4;
    localparam logic [3:0] S_SQ    = 4'd5;
    localparam logic [3:0] S_PROD  = 4'd6;
    localparam logic [3:0] S_ADD   = 4'd7;
    localparam logic [3:0] S_OUT   = 4'd8;

    localparam int LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_MAX = (LAT_MAX > COS_TIMEOUT) ? LAT_MAX : COS_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] ADD_LAST = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] COS_LAST = CW'(COS_TIMEOUT);

    localparam logic [31:0] F_128    = 32'h4300_0000;
    localparam logic [31:0] F_INV128 = 32'h3C00_0000;
    localparam logic [31:0] F_HALF   = 32'h3F00_0000;
    localparam logic [31:0] F_QNAN   = 32'h7FC0_0000;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   x_q, x_d, t_q, t_d, c_q, c_d, h_q, h_d, s_q, s_d, p_q, p_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;
    logic          cos_timeout;

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign err       = err_q;
    assign cos_reset = reset || cos_timeout;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        x_d         = x_q;
        t_d         = t_q;
        c_d         = c_q;
        h_d         = h_q;
        s_d         = s_q;
        p_d         = p_q;
        result_d    = result_q;
        err_d       = err_q;
        mul_a       = '0;
        mul_b       = '0;
        add_a       = '0;
        add_b       = '0;
        add_sub     = 1'b0;
        cos_angle   = '0;
        cos_start   = 1'b0;
        cos_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    x_d = data;
                    // All-ones exponent (Inf or NaN) skips the datapath entirely.
                    if (&data[30:23]) begin
                        result_d = F_QNAN;
                        err_d    = 1'b1;
                        state_d  = S_OUT;
                    end else begin
                        state_d = S_SUB;
                    end
                end
            end
            S_SUB: begin
                add_a   = x_q;
                add_b   = F_128;
                add_sub = 1'b1;
                if (cnt_q == ADD_LAST) begin
                    t_d     = add_res;
                    cnt_d   = '0;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                mul_a = t_q;
                mul_b = F_INV128;
                if (cnt_q == MUL_LAST) begin
                    t_d     = mul_res;
                    cnt_d   = '0;
                    state_d = S_COS;
                end
            end
            S_COS: begin
                cos_angle = t_q;
                cos_start = (cnt_q == '0);
                // A done seen in the start cycle belongs to no request of ours.
                if (cnt_q != '0 && cos_done) begin
                    c_d     = cos_res;
                    cnt_d   = '0;
                    state_d = S_HALF;
                end else if (cnt_q == COS_LAST) begin
                    cos_timeout = 1'b1;
                    result_d    = F_QNAN;
                    err_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_OUT;
                end
            end
            S_HALF: begin
                mul_a = F_HALF;
                mul_b = x_q;
                if (cnt_q == MUL_LAST) begin
                    h_d     = mul_res;
                    cnt_d   = '0;
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                mul_a = x_q;
                mul_b = x_q;
                if (cnt_q == MUL_LAST) begin
                    s_d     = mul_res;
                    cnt_d   = '0;
                    state_d = S_PROD;
                end
            end
            S_PROD: begin
                mul_a = s_q;
                mul_b = c_q;
                if (cnt_q == MUL_LAST) begin
                    p_d     = mul_res;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                add_a = h_q;
                add_b = p_q;
                if (cnt_q == ADD_LAST) begin
                    result_d = add_res;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                cnt_d = '0;
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            t_q      <= '0;
            c_q      <= '0;
            h_q      <= '0;
            s_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            t_q      <= t_d;
            c_q      <= c_d;
            h_q      <= h_d;
            s_q      <= s_d;
            p_q      <= p_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule
